instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch unit: initiator side of the instr_mem read port. Owns the PC, issues
//  byte addresses to instr_mem (1-cycle synchronous read) and presents the returned word
//  with its PC to decode. Supports consumer stall and branch/jump redirect.
//  Sits between instr_mem and the decode stage of the single-cycle/pipelined core.
// PARAMETERS
//  ARCH       32    instruction/data word width (friscv_sv_pkg::ARCH)
//  RAM_DEPTH  4096  instr_mem depth; ADDR_W = $clog2(RAM_DEPTH) byte-address bits
//  RESET_PC   0     PC after reset; must be word aligned ([1:0]==2'b00)
// PORTS
//  clk                 in   1       clock, all state updates on rising edge
//  rst                 in   1       synchronous reset, active high
//  stall_in            in   1       decode not accepting instr_out this cycle
//  branch_taken_in     in   1       redirect request
//  branch_target_in    in   ADDR_W  redirect byte address
//  instr_addr_byte_out out  ADDR_W  byte address to instr_mem.instr_addr_byte_in
//  instr_data_in       in   ARCH    instr_mem.instr_data_out (word addr>>2, 1-cycle latency)
//  instr_valid_out     out  1       instr_out/pc_out hold a valid instruction
//  instr_out           out  ARCH    fetched instruction (= instr_data_in)
//  pc_out              out  ADDR_W  byte PC of instr_out
//  misalign_err_out    out  1       1-cycle pulse: branch target had [1:0]!=0
// BEHAVIOUR
//  Regs: fetch_pc F, inflight_pc P, state {S_FILL, S_RUN}, misalign flag.
//  Reset (rst=1): F<=RESET_PC, P<=RESET_PC, state<=S_FILL, misalign<=0.
//   Outputs while rst: instr_valid_out=0, pc_out=RESET_PC, addr_out=RESET_PC, err=0.
//  instr_valid_out = (state==S_RUN); instr_out = instr_data_in; pc_out = P (combinational).
//  Address mux: addr_out = (state==S_RUN && stall_in && !branch_taken_in) ? P : F.
//   Re-reading P during stall makes next-cycle instr_data_in repeat the held instruction.
//  S_FILL (no branch): P<=F, F<=F+4, ->S_RUN. stall_in ignored (nothing presented).
//  S_RUN, !stall, !branch: P<=F, F<=F+4, stay S_RUN (1 instr/cycle).
//  S_RUN, stall, !branch: F,P hold, stay S_RUN; same pc/instr re-presented next cycle.
//  branch_taken_in (any state, priority over stall): F<={target[ADDR_W-1:2],2'b00},
//   ->S_FILL; current-cycle outputs unchanged; in-flight word squashed (valid=0 next cycle).
//   Target instruction valid 2 cycles after branch asserted.
//   misalign<=|target[1:0]; misalign_err_out = misalign (registered, else 0 next cycle).
//  Arithmetic: F+4 modulo 2^ADDR_W; wraps RAM_DEPTH-4 -> 0 silently, no error.
//  Reset mid-operation (incl. during stall/fill) overrides everything; restart from RESET_PC.
//  Latency: reset release -> first valid instr 1 cycle; stall release -> next instr 1 cycle.
//  No instruction is skipped or duplicated across any stall/branch sequence except via
//   re-presentation under stall_in=1.
// TESTING (instr_mem init: word k = k for k=0..15, word 16 = 0xDEADBEEF)
//  1 rst=1 2 cycles -> valid=0, addr=0; release -> 1 cycle later pc=0/instr=0, then
//    pc=4/1 ... pc=60/0xF, pc=64/0xDEADBEEF, one per cycle.
//  2 stall_in=1 for 3 cycles while pc_out=8 -> pc=8/instr=2 held, addr=8 all 3 cycles;
//    release -> pc=12/3, pc=16/4, no skip or duplicate.
//  3 branch to 0x28 while pc_out=16 -> next cycle valid=0, then pc=0x28/0xA, pc=0x2C/0xB.
//  4 branch to 0x0E with stall_in=1 same cycle -> err pulses 1 cycle next cycle, valid=0,
//    then pc=0x0C/instr=3 (branch wins over stall).
//  5 RESET_PC=RAM_DEPTH-8 -> pc_out 0xFF8, 0xFFC, 0x000, 0x004 (wrap, no error).
//  6 rst=1 mid-stall at pc=20 -> next cycle valid=0, addr=RESET_PC; release -> pc=0/instr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives byte addresses into a 1-cycle synchronous
// instruction memory and presents each returned word with its PC to decode.
module instr_fetch #(
    parameter int          ARCH      = 32,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_in,
    input  logic                         branch_taken_in,
    input  logic [$clog2(RAM_DEPTH)-1:0] branch_target_in,
    output logic [$clog2(RAM_DEPTH)-1:0] instr_addr_byte_out,
    input  logic [ARCH-1:0]              instr_data_in,
    output logic                         instr_valid_out,
    output logic [ARCH-1:0]              instr_out,
    output logic [$clog2(RAM_DEPTH)-1:0] pc_out,
    output logic                         misalign_err_out
);

    localparam int                ADDR_W     = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic              misalign_r;
    logic              run_s;

    assign run_s     = (state_r == S_RUN);
    assign instr_out = instr_data_in;

    // PC sequencing: a redirect beats a stall; a stall freezes both PCs so the held word is re-read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FILL;
            fetch_pc_r    <= RESET_ADDR;
            inflight_pc_r <= RESET_ADDR;
            misalign_r    <= 1'b0;
        end else if (branch_taken_in) begin
            state_r    <= S_FILL;
            fetch_pc_r <= {branch_target_in[ADDR_W-1:2], 2'b00};
            misalign_r <= |branch_target_in[1:0];
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                S_FILL: begin
                    inflight_pc_r <= fetch_pc_r;
                    fetch_pc_r    <= fetch_pc_r + PC_STEP;
                    state_r       <= S_RUN;
                end
                S_RUN: begin
                    if (!stall_in) begin
                        inflight_pc_r <= fetch_pc_r;
                        fetch_pc_r    <= fetch_pc_r + PC_STEP;
                    end else begin
                        inflight_pc_r <= inflight_pc_r;
                        fetch_pc_r    <= fetch_pc_r;
                    end
                end
                default: begin
                    state_r <= S_FILL;
                end
            endcase
        end
    end

    // Output view: reset forces the idle picture immediately, otherwise state-driven address mux.
    always_comb begin
        instr_valid_out     = 1'b0;
        pc_out              = RESET_ADDR;
        instr_addr_byte_out = RESET_ADDR;
        misalign_err_out    = 1'b0;
        if (rst) begin
            instr_valid_out     = 1'b0;
            pc_out              = RESET_ADDR;
            instr_addr_byte_out = RESET_ADDR;
            misalign_err_out    = 1'b0;
        end else begin
            instr_valid_out  = run_s;
            pc_out           = inflight_pc_r;
            misalign_err_out = misalign_r;
            if (run_s && stall_in && !branch_taken_in) begin
                instr_addr_byte_out = inflight_pc_r;
            end else begin
                instr_addr_byte_out = fetch_pc_r;
            end
        end
    end

endmodule
